// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract controller.
// Operands are latched on start, then summed one 4-bit nibble per cycle
// (LSB first) through a single four_bit_parallel_adder. Subtraction is
// A + ~B + 1: the B nibble is inverted and the initial carry is forced to 1.

// One-bit full adder cell used to build the nibble adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// Four-bit ripple adder: A + B + Cin -> S, Cout.
module four_bit_parallel_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;
  assign cout = c[4];

  for (genvar i = 0; i < 4; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end
endmodule

// Controller: IDLE -> RUN (NIBBLES cycles) -> DONE (one cycle) -> IDLE.
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   overflow
);
  // A single-nibble operand still needs a 1-bit index register.
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state;
  logic [NIBBLES-1:0][3:0]   a_reg;
  logic [NIBBLES-1:0][3:0]   b_reg;
  logic [NIBBLES-1:0][3:0]   res_reg;
  logic                      sub_reg;
  logic                      carry_reg;
  logic [IDX_W-1:0]          idx;

  logic [3:0]                add_a;
  logic [3:0]                add_b;
  logic [3:0]                add_s;
  logic                      add_c;
  logic                      last;

  // Nibble selection and conditional B inversion feeding the shared adder.
  always_comb begin
    add_a = a_reg[idx];
    add_b = b_reg[idx] ^ {4{sub_reg}};
    last  = (idx == LAST_IDX);
  end

  four_bit_parallel_adder u_add (
    .a   (add_a),
    .b   (add_b),
    .cin (carry_reg),
    .s   (add_s),
    .cout(add_c)
  );

  assign result = res_reg;

  // Sequencer with registered busy/done/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      sub_reg   <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            sub_reg   <= sub;
            carry_reg <= sub;
            idx       <= '0;
            res_reg   <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          res_reg[idx] <= add_s;
          carry_reg    <= add_c;
          idx          <= idx + 1'b1;
          if (last) begin
            // Signed overflow: operands (after B inversion) agree in sign
            // but the top result nibble's sign differs.
            cout     <= add_c;
            overflow <= (add_a[3] == add_b[3]) && (add_s[3] != add_a[3]);
            idx      <= '0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl with a transaction-level
// reference model and a per-cycle compare process.
module tb_nibble_serial_adder_ctrl;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .sub     (sub),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .cout    (cout),
    .overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from signed/unsigned integer math.
  task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W-1:0] r, output logic c, output logic v);
    int sa, sb, sv, ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = int'(a);
    ub = int'(b);
    sv = s ? (sa - sb) : (sa + sb);
    r  = s ? W'(ua - ub) : W'(ua + ub);
    c  = s ? (ua >= ub) : ((ua + ub) >= (1 << W));
    v  = (sv > (1 << (W-1)) - 1) || (sv < -(1 << (W-1)));
  endtask

  // Model state: accept-to-done is NIBBLES further edges, then one DONE cycle.
  bit           m_valid = 0;
  bit           m_active = 0;
  int           m_cnt = 0;
  logic [W-1:0] m_res, p_res;
  logic         m_cout, m_ovf, p_cout, p_ovf;

  always @(posedge clk) begin
    m_valid = 1;
    if (!rst_n) begin
      m_active = 0;
      m_cnt    = 0;
      m_res    = '0;
      m_cout   = 1'b0;
      m_ovf    = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1;
        m_cnt    = 0;
        ref_op(op_a, op_b, sub, p_res, p_cout, p_ovf);
      end
    end else begin
      m_cnt++;
      if (m_cnt == NIBBLES) begin
        m_res  = p_res;
        m_cout = p_cout;
        m_ovf  = p_ovf;
      end else if (m_cnt == NIBBLES + 1) begin
        m_active = 0;
      end
    end
  end

  // Compare every cycle; status outputs only when they must be stable.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", busy, m_active);
      chk("done", done, m_active && (m_cnt == NIBBLES));
      if (!m_active || (m_cnt == NIBBLES)) begin
        chk("result", result, m_res);
        chk("cout", cout, m_cout);
        chk("overflow", overflow, m_ovf);
      end
    end
  end

  // One operation with hand-computed literals; ends at the negedge after done.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] er, input logic ec, input logic ev);
    int n;
    @(negedge clk);
    start = 1'b1; sub = s; op_a = a; op_b = b;
    @(posedge clk);
    n = 1;  // the accept edge counts as edge 1
    @(negedge clk);
    start = 1'b0; op_a = ~a; op_b = ~b; sub = ~s;
    while (!done && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({name, "_latency"}, n, NIBBLES + 1);
    chk({name, "_result"}, result, er);
    chk({name, "_cout"}, cout, ec);
    chk({name, "_ovf"}, overflow, ev);
    @(negedge clk);
    chk({name, "_done_width"}, done, 1'b0);
  endtask

  logic [W-1:0] ha [3] = '{16'h1234, 16'hABCD, 16'h0100};
  logic [W-1:0] hb [3] = '{16'h1111, 16'h1234, 16'h0001};
  logic         hs [3] = '{1'b0, 1'b0, 1'b1};
  logic [W-1:0] hr [3] = '{16'h2345, 16'hBE01, 16'h00FF};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    rst_n = 1'b1;

    run_op("add_3_5",   16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0);
    run_op("add_ffff",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_7fff",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_5_7",   16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_8000",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Held start: one accept every NIBBLES+2 cycles; operands scrambled
    // while the operation is in flight.
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < NIBBLES + 2; j++) begin
        @(negedge clk);
        if (j == NIBBLES + 1) begin
          chk("held_done", done, 1'b1);
          chk("held_result", result, hr[k]);
        end
        if (j == 0) begin
          start = 1'b1; op_a = ha[k]; op_b = hb[k]; sub = hs[k];
        end else begin
          op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
        end
      end
    end
    @(negedge clk);
    start = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during the second RUN cycle aborts with no done pulse.
    start = 1'b1; op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_result", result, 16'h0000);
    for (int i = 0; i < NIBBLES + 2; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 1'b0);
    end
    run_op("add_1_1", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
